// File: rtl/jk_pkg.sv
// Shared FSM state encoding and JK excitation helper for the JK step driver.
package jk_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Inverse of the JK characteristic table; don't-cares resolved to 0, so J=K=1 never occurs.
   function automatic logic [1:0] jk_excite(input logic q_bit, input logic nxt_bit);
      return {~q_bit & nxt_bit, q_bit & ~nxt_bit};
   endfunction

endpackage

// File: rtl/jk_cell.sv
// One behavioural JK flip-flop: 00 hold, 01 clear, 10 set, 11 toggle.
module jk_cell (
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            2'b11:   q <= ~q;
            default: q <= q;
         endcase
      end
   end

endmodule

// File: rtl/jk_step_driver.sv
// Walks a bank of JK cells one step per clock toward a requested target by
// computing the desired next value and converting it into J/K excitation.
module jk_step_driver
   import jk_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic [WIDTH-1:0] target,
   input  logic             abort,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] j_out,
   output logic [WIDTH-1:0] k_out,
   output logic             busy,
   output logic             done
);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [WIDTH-1:0] tgt;
   logic [WIDTH-1:0] nxt;
   logic             capture;

   always_comb begin
      state_nxt = state;
      nxt       = q;
      capture   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (load) begin
               nxt = load_val;
            end else if (start) begin
               capture   = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (q == tgt) begin
               state_nxt = ST_DONE;
            end else if (q < tgt) begin
               nxt = q + 1'b1;
            end else begin
               nxt = q - 1'b1;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      // Keep excitation quiet while reset is held, whatever the other inputs do.
      if (rst) begin
         nxt = q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         tgt   <= '0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            tgt <= target;
         end
      end
   end

   always_comb begin
      j_out = '0;
      k_out = '0;
      for (int i = 0; i < WIDTH; i++) begin
         {j_out[i], k_out[i]} = jk_excite(q[i], nxt[i]);
      end
   end

   // q changes only through the JK cells.
   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      jk_cell u_cell (
         .clk (clk),
         .rst (rst),
         .j   (j_out[g]),
         .k   (k_out[g]),
         .q   (q[g])
      );
   end

   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_jk_step_driver.sv
// Directed-vector bench for jk_step_driver with hand-computed expectations.
module tb_jk_step_driver;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             start;
   logic [WIDTH-1:0] target;
   logic             abort;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] j_out;
   logic [WIDTH-1:0] k_out;
   logic             busy;
   logic             done;

   int vectors;
   int miscompares;

   jk_step_driver #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .start    (start),
      .target   (target),
      .abort    (abort),
      .q        (q),
      .j_out    (j_out),
      .k_out    (k_out),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst      = 1'b1;
      load     = 1'b0;
      load_val = '0;
      start    = 1'b0;
      target   = '0;
      abort    = 1'b0;

      // 1: reset state before the first edge, even with load asserted
      #1;
      load     = 1'b1;
      load_val = 4'hF;
      #1;
      chk("rst_q", 8'(q), 8'h0);
      chk("rst_busy", 8'(busy), 8'h0);
      chk("rst_done", 8'(done), 8'h0);
      chk("rst_j", 8'(j_out), 8'h0);
      chk("rst_k", 8'(k_out), 8'h0);
      load = 1'b0;
      tick();
      chk("rst_hold_q", 8'(q), 8'h0);
      rst = 1'b0;

      // 2: load 3, count up to 6
      load = 1'b1; load_val = 4'h3;
      tick();
      chk("t2_load_q", 8'(q), 8'h3);
      load = 1'b0; start = 1'b1; target = 4'h6;
      #1;
      chk("t2_idle_j", 8'(j_out), 8'h0);
      tick();
      start = 1'b0;
      chk("t2_e0_busy", 8'(busy), 8'h1);
      chk("t2_e0_q", 8'(q), 8'h3);
      chk("t2_step_j", 8'(j_out), 8'h4);
      chk("t2_step_k", 8'(k_out), 8'h3);
      tick(); chk("t2_e1_q", 8'(q), 8'h4);
      tick(); chk("t2_e2_q", 8'(q), 8'h5);
      tick(); chk("t2_e3_q", 8'(q), 8'h6);
      chk("t2_e3_done", 8'(done), 8'h0);
      chk("t2_e3_busy", 8'(busy), 8'h1);
      tick();
      chk("t2_e4_done", 8'(done), 8'h1);
      chk("t2_e4_busy", 8'(busy), 8'h0);
      chk("t2_e4_q", 8'(q), 8'h6);
      tick();
      chk("t2_e5_done", 8'(done), 8'h0);

      // 3: load 9, count down to 7
      load = 1'b1; load_val = 4'h9;
      tick();
      load = 1'b0; start = 1'b1; target = 4'h7;
      tick();
      start = 1'b0;
      chk("t3_step_k", 8'(k_out), 8'h1);
      chk("t3_step_j", 8'(j_out), 8'h0);
      tick(); chk("t3_e1_q", 8'(q), 8'h8);
      tick(); chk("t3_e2_q", 8'(q), 8'h7);
      chk("t3_e2_busy", 8'(busy), 8'h1);
      tick();
      chk("t3_e3_done", 8'(done), 8'h1);
      chk("t3_e3_busy", 8'(busy), 8'h0);
      tick();

      // 4: target equals current value
      load = 1'b1; load_val = 4'h5;
      tick();
      load = 1'b0; start = 1'b1; target = 4'h5;
      tick();
      start = 1'b0;
      chk("t4_e0_j", 8'(j_out), 8'h0);
      chk("t4_e0_k", 8'(k_out), 8'h0);
      chk("t4_e0_busy", 8'(busy), 8'h1);
      tick();
      chk("t4_e1_done", 8'(done), 8'h1);
      chk("t4_e1_q", 8'(q), 8'h5);
      chk("t4_e1_jk", 8'({j_out, k_out}), 8'h0);
      tick();
      chk("t4_e2_done", 8'(done), 8'h0);
      chk("t4_e2_q", 8'(q), 8'h5);

      // 5: abort at q=5, then load beats start
      load = 1'b1; load_val = 4'h2;
      tick();
      load = 1'b0; start = 1'b1; target = 4'hC;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      chk("t5_pre_q", 8'(q), 8'h5);
      abort = 1'b1;
      #1;
      chk("t5_abort_jk", 8'({j_out, k_out}), 8'h0);
      tick();
      abort = 1'b0;
      chk("t5_abort_q", 8'(q), 8'h5);
      chk("t5_abort_busy", 8'(busy), 8'h0);
      chk("t5_abort_done", 8'(done), 8'h0);
      start = 1'b1; load = 1'b1; load_val = 4'hA;
      tick();
      start = 1'b0; load = 1'b0;
      chk("t5_load_q", 8'(q), 8'hA);
      chk("t5_load_busy", 8'(busy), 8'h0);
      tick();
      chk("t5_dropped_busy", 8'(busy), 8'h0);
      chk("t5_dropped_q", 8'(q), 8'hA);

      // 6: async reset mid-run, then full 0 -> F run with load/start ignored
      load = 1'b1; load_val = 4'h5;
      tick();
      load = 1'b0; start = 1'b1; target = 4'hF;
      tick();
      start = 1'b0;
      tick(); tick();
      chk("t6_pre_q", 8'(q), 8'h7);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_q", 8'(q), 8'h0);
      chk("t6_rst_busy", 8'(busy), 8'h0);
      rst = 1'b0;
      start = 1'b1; target = 4'hF;
      tick();
      target = 4'h0;
      load = 1'b1; load_val = 4'h0;
      for (int s = 1; s <= 15; s++) begin
         tick();
         chk($sformatf("t6_step%0d_q", s), 8'(q), 8'(s));
      end
      chk("t6_e15_busy", 8'(busy), 8'h1);
      chk("t6_e15_done", 8'(done), 8'h0);
      load  = 1'b0;
      start = 1'b0;
      tick();
      chk("t6_e16_done", 8'(done), 8'h1);
      chk("t6_e16_q", 8'(q), 8'hF);
      tick();
      chk("t6_e17_done", 8'(done), 8'h0);
      chk("t6_e17_q", 8'(q), 8'hF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
